dcache_tag_ctrl: RTL and testbench

Sequencer and port arbiter for the data-cache tag store SRAM. It owns the SRAM's single port and shares it between three users: a hardware invalidation sweep, a refill/tag-write requester, and a lookup requester. The sweep runs automatically after reset and on explicit flush. Lookups get a registered hit result one cycle after grant. It sits between the dcache miss/flush logic and the tag store instance, and replaces the behavioural simulation-only reset of the valid bits with a real sweep.

---
 rtl/dcache_tag_ctrl.sv | 129 ++++++++++++
 tb/tb_dcache_tag_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_tag_ctrl.sv
// rtl/dcache_tag_ctrl.sv - tag store SRAM sequencer: reset/flush invalidation sweep plus write/lookup arbitration
module dcache_tag_ctrl #(
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned VALID_BIT  = 31
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_req_i,
  output logic                          flush_ack_o,
  output logic                          busy_o,
  input  logic                          wr_req_i,
  output logic                          wr_gnt_o,
  input  logic [$clog2(NUM_WORDS)-1:0]  wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          rd_req_i,
  output logic                          rd_gnt_o,
  input  logic [$clog2(NUM_WORDS)-1:0]  rd_addr_i,
  input  logic [DATA_WIDTH-1:0]         rd_tag_i,
  output logic                          rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]         rd_rdata_o,
  output logic                          rd_hit_o,
  output logic                          sram_en_o,
  output logic                          sram_we_o,
  output logic [DATA_WIDTH/8-1:0]       sram_be_o,
  output logic [$clog2(NUM_WORDS)-1:0]  sram_addr_o,
  output logic [DATA_WIDTH-1:0]         sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]         sram_rdata_i
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  rvalid_q;
  logic                  flush_ack_q;
  logic [DATA_WIDTH-1:0] tag_q;
  logic [DATA_WIDTH-1:0] tag_diff;
  logic                  sweeping;

  assign sweeping    = (state_q != ST_IDLE);
  assign busy_o      = sweeping;
  assign flush_ack_o = flush_ack_q;
  assign rd_rvalid_o = rvalid_q;
  assign rd_rdata_o  = sram_rdata_i;
  // Only full-word writes ever happen, so every byte lane is always enabled.
  assign sram_be_o   = '1;

  // SRAM port mux and grants: sweep owns the port, otherwise flush > write > lookup.
  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    wr_gnt_o     = 1'b0;
    rd_gnt_o     = 1'b0;
    if (sweeping) begin
      sram_en_o   = 1'b1;
      sram_we_o   = 1'b1;
      sram_addr_o = idx_q;
    end else if (!flush_req_i) begin
      if (wr_req_i) begin
        wr_gnt_o     = 1'b1;
        sram_en_o    = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = wr_addr_i;
        sram_wdata_o = wr_data_i;
      end else if (rd_req_i) begin
        rd_gnt_o    = 1'b1;
        sram_en_o   = 1'b1;
        sram_addr_o = rd_addr_i;
      end
    end
  end

  // Sweep sequencer, lookup pipeline register and flush acknowledge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      rvalid_q    <= 1'b0;
      flush_ack_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      rvalid_q    <= rd_gnt_o;
      flush_ack_q <= 1'b0;
      if (rd_gnt_o) begin
        tag_q <= rd_tag_i;
      end
      case (state_q)
        ST_INIT, ST_FLUSH: begin
          idx_q <= idx_q + IDX_ONE;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            if (state_q == ST_FLUSH) begin
              flush_ack_q <= 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (flush_req_i) begin
            state_q <= ST_FLUSH;
          end
        end
        default: begin
          state_q <= ST_INIT;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Tag compare ignores the valid position; validity is checked separately.
  always_comb begin
    tag_diff            = sram_rdata_i ^ tag_q;
    tag_diff[VALID_BIT] = 1'b0;
  end

  assign rd_hit_o = rvalid_q & sram_rdata_i[VALID_BIT] & ~(|tag_diff);

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// tb/tb_dcache_tag_ctrl.sv - directed bench for dcache_tag_ctrl with 8-word and 2-word instances
module tb_dcache_tag_ctrl;

  logic clk_i;
  int   n_checks;
  int   n_pass;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instance A: 8 words, 16-bit tags, valid at bit 15
  logic        rst_a, flush_req_a, flush_ack_a, busy_a;
  logic        wr_req_a, wr_gnt_a, rd_req_a, rd_gnt_a, rd_rvalid_a, rd_hit_a;
  logic [2:0]  wr_addr_a, rd_addr_a, addr_a;
  logic [15:0] wr_data_a, rd_tag_a, rd_rdata_a, wdata_a, rdata_a;
  logic        en_a, we_a;
  logic [1:0]  be_a;
  logic [15:0] mem_a [8];

  dcache_tag_ctrl #(.NUM_WORDS(8), .DATA_WIDTH(16), .VALID_BIT(15)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_a),
    .flush_req_i(flush_req_a), .flush_ack_o(flush_ack_a), .busy_o(busy_a),
    .wr_req_i(wr_req_a), .wr_gnt_o(wr_gnt_a), .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a),
    .rd_req_i(rd_req_a), .rd_gnt_o(rd_gnt_a), .rd_addr_i(rd_addr_a), .rd_tag_i(rd_tag_a),
    .rd_rvalid_o(rd_rvalid_a), .rd_rdata_o(rd_rdata_a), .rd_hit_o(rd_hit_a),
    .sram_en_o(en_a), .sram_we_o(we_a), .sram_be_o(be_a), .sram_addr_o(addr_a),
    .sram_wdata_o(wdata_a), .sram_rdata_i(rdata_a)
  );

  always @(posedge clk_i) begin
    if (en_a) begin
      if (we_a) mem_a[addr_a] <= wdata_a;
      else      rdata_a <= mem_a[addr_a];
    end
  end

  // Instance B: 2 words, same tag format
  logic        rst_b, flush_req_b, flush_ack_b, busy_b;
  logic        wr_req_b, wr_gnt_b, rd_req_b, rd_gnt_b, rd_rvalid_b, rd_hit_b;
  logic [0:0]  wr_addr_b, rd_addr_b, addr_b;
  logic [15:0] wr_data_b, rd_tag_b, rd_rdata_b, wdata_b, rdata_b;
  logic        en_b, we_b;
  logic [1:0]  be_b;
  logic [15:0] mem_b [2];

  dcache_tag_ctrl #(.NUM_WORDS(2), .DATA_WIDTH(16), .VALID_BIT(15)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_b),
    .flush_req_i(flush_req_b), .flush_ack_o(flush_ack_b), .busy_o(busy_b),
    .wr_req_i(wr_req_b), .wr_gnt_o(wr_gnt_b), .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b),
    .rd_req_i(rd_req_b), .rd_gnt_o(rd_gnt_b), .rd_addr_i(rd_addr_b), .rd_tag_i(rd_tag_b),
    .rd_rvalid_o(rd_rvalid_b), .rd_rdata_o(rd_rdata_b), .rd_hit_o(rd_hit_b),
    .sram_en_o(en_b), .sram_we_o(we_b), .sram_be_o(be_b), .sram_addr_o(addr_b),
    .sram_wdata_o(wdata_b), .sram_rdata_i(rdata_b)
  );

  always @(posedge clk_i) begin
    if (en_b) begin
      if (we_b) mem_b[addr_b] <= wdata_b;
      else      rdata_b <= mem_b[addr_b];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Checks one sweep cycle of instance A (drive values already settled)
  task automatic chk_sweep_a(input string tag, input int k);
    chk({tag, "_busy"}, busy_a, 1);
    chk({tag, "_en"}, en_a, 1);
    chk({tag, "_we"}, we_a, 1);
    chk({tag, "_addr"}, addr_a, k);
    chk({tag, "_wdata"}, wdata_a, 0);
    chk({tag, "_gnt"}, {wr_gnt_a, rd_gnt_a}, 0);
    chk({tag, "_ack"}, flush_ack_a, 0);
  endtask

  task automatic chk_sweep_b(input string tag, input int k);
    chk({tag, "_busy"}, busy_b, 1);
    chk({tag, "_en_we"}, {en_b, we_b}, 2'b11);
    chk({tag, "_addr"}, addr_b, k);
    chk({tag, "_wdata"}, wdata_b, 0);
    chk({tag, "_gnt"}, {wr_gnt_b, rd_gnt_b}, 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_a = 1'b1; flush_req_a = 1'b0; wr_req_a = 1'b0; rd_req_a = 1'b0;
    wr_addr_a = '0; wr_data_a = '0; rd_addr_a = '0; rd_tag_a = '0;
    rst_b = 1'b1; flush_req_b = 1'b0; wr_req_b = 1'b0; rd_req_b = 1'b0;
    wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0; rd_tag_b = '0;

    // ---- reset values, with a lookup already pending
    @(negedge clk_i);
    rd_req_a = 1'b1; rd_addr_a = 3'd5; rd_tag_a = 16'h0000;
    @(negedge clk_i);
    #1;
    chk("rst_busy", busy_a, 1);
    chk("rst_en_we", {en_a, we_a}, 2'b11);
    chk("rst_be", be_a, 2'b11);
    chk("rst_addr", addr_a, 0);
    chk("rst_wdata", wdata_a, 0);
    chk("rst_gnt", {wr_gnt_a, rd_gnt_a}, 0);
    chk("rst_rvalid", rd_rvalid_a, 0);
    chk("rst_hit", rd_hit_a, 0);
    chk("rst_ack", flush_ack_a, 0);

    // ---- INIT sweep: 8 cycles, then the held lookup of idx 5 is granted
    @(negedge clk_i);
    rst_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_sweep_a("init", k);
      @(negedge clk_i);
    end
    #1;
    chk("init_done_busy", busy_a, 0);
    chk("init_rd5_gnt", rd_gnt_a, 1);
    chk("init_rd5_we", {en_a, we_a}, 2'b10);
    chk("init_rd5_addr", addr_a, 5);
    @(negedge clk_i);
    rd_req_a = 1'b0;
    #1;
    chk("init_rd5_rvalid", rd_rvalid_a, 1);
    chk("init_rd5_hit", rd_hit_a, 0);
    chk("init_rd5_rdata", rd_rdata_a, 16'h0000);

    // ---- write idx 3 = valid|0x2A, then back-to-back lookups
    @(negedge clk_i);
    wr_req_a = 1'b1; wr_addr_a = 3'd3; wr_data_a = 16'h802A;
    #1;
    chk("wr3_gnt", wr_gnt_a, 1);
    chk("wr3_rdgnt", rd_gnt_a, 0);
    chk("wr3_en_we", {en_a, we_a}, 2'b11);
    chk("wr3_addr", addr_a, 3);
    chk("wr3_wdata", wdata_a, 16'h802A);
    chk("wr3_be", be_a, 2'b11);
    @(negedge clk_i);
    wr_req_a = 1'b0;
    rd_req_a = 1'b1; rd_addr_a = 3'd3; rd_tag_a = 16'h802A;
    #1;
    chk("rd3a_gnt", rd_gnt_a, 1);
    @(negedge clk_i);
    rd_tag_a = 16'h002B;
    #1;
    chk("rd3a_rvalid", rd_rvalid_a, 1);
    chk("rd3a_hit", rd_hit_a, 1);
    chk("rd3a_rdata", rd_rdata_a, 16'h802A);
    chk("rd3b_gnt", rd_gnt_a, 1);
    @(negedge clk_i);
    rd_req_a = 1'b0;
    #1;
    chk("rd3b_rvalid", rd_rvalid_a, 1);
    chk("rd3b_hit", rd_hit_a, 0);

    // ---- write beats read in the same cycle; read returns the new word
    @(negedge clk_i);
    wr_req_a = 1'b1; wr_addr_a = 3'd6; wr_data_a = 16'h8055;
    rd_req_a = 1'b1; rd_addr_a = 3'd6; rd_tag_a = 16'h0055;
    #1;
    chk("prio_wrgnt", wr_gnt_a, 1);
    chk("prio_rdgnt", rd_gnt_a, 0);
    @(negedge clk_i);
    wr_req_a = 1'b0;
    #1;
    chk("prio_rd_gnt", rd_gnt_a, 1);
    chk("prio_rd_addr", addr_a, 6);
    // a write granted right after the lookup must not change its result
    @(negedge clk_i);
    wr_req_a = 1'b1; wr_addr_a = 3'd6; wr_data_a = 16'h8011;
    rd_req_a = 1'b0;
    #1;
    chk("prio_rd_hit", rd_hit_a, 1);
    chk("prio_rd_rdata", rd_rdata_a, 16'h8055);
    chk("wafter_gnt", wr_gnt_a, 1);
    @(negedge clk_i);
    wr_req_a = 1'b0;
    #1;
    chk("wafter_rvalid", rd_rvalid_a, 0);

    // ---- fill all entries valid, then flush with a lookup pending
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      wr_req_a = 1'b1; wr_addr_a = 3'(i); wr_data_a = 16'h8000 | 16'(i);
      #1;
      chk("fill_gnt", wr_gnt_a, 1);
    end
    @(negedge clk_i);
    wr_req_a = 1'b0;
    flush_req_a = 1'b1;
    rd_req_a = 1'b1; rd_addr_a = 3'd2; rd_tag_a = 16'h0002;
    #1;
    chk("flT_en", en_a, 0);
    chk("flT_gnt", {wr_gnt_a, rd_gnt_a}, 0);
    chk("flT_busy", busy_a, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      #1;
      chk_sweep_a("flush", k);
    end
    @(negedge clk_i);
    #1;
    chk("fl_ack", flush_ack_a, 1);
    chk("fl_ack_busy", busy_a, 0);
    flush_req_a = 1'b0;
    #1;
    chk("fl_rd_gnt", rd_gnt_a, 1);
    @(negedge clk_i);
    rd_addr_a = 3'd7; rd_tag_a = 16'h0007;
    #1;
    chk("fl_ack_once", flush_ack_a, 0);
    chk("fl_rd2_rvalid", rd_rvalid_a, 1);
    chk("fl_rd2_hit", rd_hit_a, 0);
    chk("fl_rd7_gnt", rd_gnt_a, 1);
    @(negedge clk_i);
    rd_req_a = 1'b0;
    #1;
    chk("fl_rd7_hit", rd_hit_a, 0);
    chk("fl_rd7_rdata", rd_rdata_a, 16'h0000);

    // ---- reset in the 4th flush sweep cycle: no ack, full INIT sweep again
    @(negedge clk_i);
    flush_req_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
    end
    #1;
    chk("mid_addr", addr_a, 3);
    rst_a = 1'b1;
    flush_req_a = 1'b0;
    #1;
    chk("mid_rst_addr", addr_a, 0);
    chk("mid_rst_busy", busy_a, 1);
    @(negedge clk_i);
    rst_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_sweep_a("reinit", k);
      @(negedge clk_i);
    end
    #1;
    chk("reinit_busy", busy_a, 0);
    chk("reinit_ack", flush_ack_a, 0);
    @(negedge clk_i);
    #1;
    chk("reinit_ack2", flush_ack_a, 0);

    // ---- NUM_WORDS=2: 2-cycle sweeps, index wraps, second flush restarts at 0
    rst_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk_sweep_b("b_init", k);
      @(negedge clk_i);
    end
    #1;
    chk("b_init_busy", busy_b, 0);
    wr_req_b = 1'b1; wr_addr_b = 1'b1; wr_data_b = 16'h8033;
    #1;
    chk("b_wr_gnt", wr_gnt_b, 1);
    for (int f = 0; f < 2; f++) begin
      @(negedge clk_i);
      wr_req_b = 1'b0;
      flush_req_b = 1'b1;
      #1;
      chk("b_flT_en", en_b, 0);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk_i);
        #1;
        chk_sweep_b("b_flush", k);
        chk("b_flush_ack", flush_ack_b, 0);
      end
      @(negedge clk_i);
      #1;
      chk("b_ack", flush_ack_b, 1);
      chk("b_ack_busy", busy_b, 0);
      flush_req_b = 1'b0;
    end
    rd_req_b = 1'b1; rd_addr_b = 1'b1; rd_tag_b = 16'h0033;
    #1;
    chk("b_rd_gnt", rd_gnt_b, 1);
    @(negedge clk_i);
    rd_req_b = 1'b0;
    #1;
    chk("b_rd_rvalid", rd_rvalid_b, 1);
    chk("b_rd_hit", rd_hit_b, 0);
    chk("b_ack_once", flush_ack_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
